// File: rtl/dma_channel_arbiter_if.sv
// dma_channel_arbiter_if: per-channel TileLink-UL ports plus the shared master port
interface dma_channel_arbiter_if #(
  parameter int NoC   = 2,
  parameter int TL_RS = 4
);
  logic [3*NoC-1:0]  ch_a_opcode;
  logic [3*NoC-1:0]  ch_a_param;
  logic [4*NoC-1:0]  ch_a_size;
  logic [32*NoC-1:0] ch_a_address;
  logic [4*NoC-1:0]  ch_a_mask;
  logic [32*NoC-1:0] ch_a_data;
  logic [NoC-1:0]    ch_a_corrupt;
  logic [NoC-1:0]    ch_a_valid;
  logic [NoC-1:0]    ch_a_ready;
  logic [3*NoC-1:0]  ch_d_opcode;
  logic [2*NoC-1:0]  ch_d_param;
  logic [4*NoC-1:0]  ch_d_size;
  logic [NoC-1:0]    ch_d_denied;
  logic [32*NoC-1:0] ch_d_data;
  logic [NoC-1:0]    ch_d_corrupt;
  logic [NoC-1:0]    ch_d_valid;
  logic [NoC-1:0]    ch_d_ready;
  logic [2:0]        m_a_opcode;
  logic [2:0]        m_a_param;
  logic [3:0]        m_a_size;
  logic [TL_RS-1:0]  m_a_source;
  logic [31:0]       m_a_address;
  logic [3:0]        m_a_mask;
  logic [31:0]       m_a_data;
  logic              m_a_corrupt;
  logic              m_a_valid;
  logic              m_a_ready;
  logic [2:0]        m_d_opcode;
  logic [1:0]        m_d_param;
  logic [3:0]        m_d_size;
  logic [TL_RS-1:0]  m_d_source;
  logic              m_d_denied;
  logic [31:0]       m_d_data;
  logic              m_d_corrupt;
  logic              m_d_valid;
  logic              m_d_ready;
  // master: the arbiter, which drives the shared master port
  modport master (
    input  ch_a_opcode, ch_a_param, ch_a_size, ch_a_address, ch_a_mask, ch_a_data,
           ch_a_corrupt, ch_a_valid, ch_d_ready, m_a_ready,
           m_d_opcode, m_d_param, m_d_size, m_d_source, m_d_denied, m_d_data,
           m_d_corrupt, m_d_valid,
    output ch_a_ready, ch_d_opcode, ch_d_param, ch_d_size, ch_d_denied, ch_d_data,
           ch_d_corrupt, ch_d_valid,
           m_a_opcode, m_a_param, m_a_size, m_a_source, m_a_address, m_a_mask,
           m_a_data, m_a_corrupt, m_a_valid, m_d_ready
  );
  // slave: channels plus downstream fabric as seen from outside the arbiter
  modport slave (
    output ch_a_opcode, ch_a_param, ch_a_size, ch_a_address, ch_a_mask, ch_a_data,
           ch_a_corrupt, ch_a_valid, ch_d_ready, m_a_ready,
           m_d_opcode, m_d_param, m_d_size, m_d_source, m_d_denied, m_d_data,
           m_d_corrupt, m_d_valid,
    input  ch_a_ready, ch_d_opcode, ch_d_param, ch_d_size, ch_d_denied, ch_d_data,
           ch_d_corrupt, ch_d_valid,
           m_a_opcode, m_a_param, m_a_size, m_a_source, m_a_address, m_a_mask,
           m_a_data, m_a_corrupt, m_a_valid, m_d_ready
  );
endinterface

// File: rtl/dma_channel_arbiter.sv
// dma_channel_arbiter: round-robin share of one TL-UL master port among DMA channels
module dma_channel_arbiter #(
  parameter int NoC   = 2,
  parameter int TL_RS = 4
) (
  input  logic                   dma_clock_i,
  input  logic                   dma_reset_i,
  dma_channel_arbiter_if.master  bus_io,
  output logic [NoC-1:0]         outstanding_o,
  output logic                   spurious_d_o
);
  localparam int IW = NoC > 1 ? $clog2(NoC) : 1;
  localparam int PW = 1 << IW;
  localparam logic [IW:0] NOC_W = (IW+1)'(NoC);
  logic [NoC-1:0]  outstanding_q, outstanding_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic            a_valid_q;
  logic [2:0]      a_opcode_q;
  logic [2:0]      a_param_q;
  logic [3:0]      a_size_q;
  logic [IW-1:0]   a_source_q;
  logic [31:0]     a_address_q;
  logic [3:0]      a_mask_q;
  logic [31:0]     a_data_q;
  logic            a_corrupt_q;
  logic            spurious_q;
  logic [NoC-1:0]  eligible;
  logic            slot_free;
  logic            any_elig;
  logic            accept;
  logic [IW-1:0]   gnt;
  logic [IW:0]     rot_sum [NoC];
  logic [IW-1:0]   rot_idx [NoC];
  logic [IW-1:0]   d_idx;
  logic [PW-1:0]   out_ext;
  logic [PW-1:0]   rdy_ext;
  logic            up_zero;
  logic            d_hit;
  logic            d_fire;
  // a channel that already has a request in flight may not compete
  assign eligible  = bus_io.ch_a_valid & ~outstanding_q;
  assign slot_free = ~a_valid_q | bus_io.m_a_ready;
  // candidate k of the rotating scan is channel (rr + k) mod NoC
  for (genvar k = 0; k < NoC; k++) begin : g_rot
    assign rot_sum[k] = {1'b0, rr_q} + (IW+1)'(k);
    assign rot_idx[k] = IW'(rot_sum[k] >= NOC_W ? rot_sum[k] - NOC_W : rot_sum[k]);
  end
  // pick the first eligible channel at or after the round-robin pointer
  always_comb begin
    any_elig = 1'b0;
    gnt      = '0;
    for (int j = NoC - 1; j >= 0; j--) begin
      if (eligible[rot_idx[j]]) begin
        any_elig = 1'b1;
        gnt      = rot_idx[j];
      end
    end
  end
  assign accept            = slot_free & any_elig;
  assign bus_io.ch_a_ready = accept ? NoC'(1) << gnt : '0;
  assign rr_d              = accept ? ((IW+1)'(gnt) + 1'b1 == NOC_W ? '0 : gnt + 1'b1) : rr_q;
  // D routing: only the low source bits name a channel; anything else is foreign
  assign d_idx   = bus_io.m_d_source[IW-1:0];
  assign up_zero = (bus_io.m_d_source >> IW) == '0;
  assign out_ext = PW'(outstanding_q);
  assign rdy_ext = PW'(bus_io.ch_d_ready);
  assign d_hit   = up_zero & out_ext[d_idx];
  assign d_fire  = d_hit & bus_io.m_d_valid & rdy_ext[d_idx];
  assign bus_io.m_d_ready    = d_hit ? rdy_ext[d_idx] : 1'b1;
  assign bus_io.ch_d_valid   = (d_hit & bus_io.m_d_valid) ? NoC'(1) << d_idx : '0;
  assign bus_io.ch_d_opcode  = {NoC{bus_io.m_d_opcode}};
  assign bus_io.ch_d_param   = {NoC{bus_io.m_d_param}};
  assign bus_io.ch_d_size    = {NoC{bus_io.m_d_size}};
  assign bus_io.ch_d_denied  = {NoC{bus_io.m_d_denied}};
  assign bus_io.ch_d_data    = {NoC{bus_io.m_d_data}};
  assign bus_io.ch_d_corrupt = {NoC{bus_io.m_d_corrupt}};
  // set on grant, cleared on the D handshake; the two never hit the same channel together
  always_comb begin
    outstanding_d = outstanding_q;
    if (accept) outstanding_d[gnt] = 1'b1;
    if (d_fire) outstanding_d[d_idx] = 1'b0;
  end
  // control state: in-flight flags, round-robin pointer, spurious-beat pulse
  always_ff @(posedge dma_clock_i or posedge dma_reset_i) begin
    if (dma_reset_i) begin
      outstanding_q <= '0;
      rr_q          <= '0;
      spurious_q    <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      rr_q          <= rr_d;
      spurious_q    <= bus_io.m_d_valid & ~d_hit;
    end
  end
  // registered A stage: load the winner, hold while stalled, drain when idle
  always_ff @(posedge dma_clock_i or posedge dma_reset_i) begin
    if (dma_reset_i) begin
      a_valid_q   <= 1'b0;
      a_opcode_q  <= '0;
      a_param_q   <= '0;
      a_size_q    <= '0;
      a_source_q  <= '0;
      a_address_q <= '0;
      a_mask_q    <= '0;
      a_data_q    <= '0;
      a_corrupt_q <= 1'b0;
    end else if (accept) begin
      a_valid_q   <= 1'b1;
      a_opcode_q  <= bus_io.ch_a_opcode[gnt*3 +: 3];
      a_param_q   <= bus_io.ch_a_param[gnt*3 +: 3];
      a_size_q    <= bus_io.ch_a_size[gnt*4 +: 4];
      a_source_q  <= gnt;
      a_address_q <= bus_io.ch_a_address[gnt*32 +: 32];
      a_mask_q    <= bus_io.ch_a_mask[gnt*4 +: 4];
      a_data_q    <= bus_io.ch_a_data[gnt*32 +: 32];
      a_corrupt_q <= bus_io.ch_a_corrupt[gnt];
    end else if (slot_free) begin
      a_valid_q   <= 1'b0;
    end
  end
  assign bus_io.m_a_valid   = a_valid_q;
  assign bus_io.m_a_opcode  = a_opcode_q;
  assign bus_io.m_a_param   = a_param_q;
  assign bus_io.m_a_size    = a_size_q;
  assign bus_io.m_a_source  = TL_RS'(a_source_q);
  assign bus_io.m_a_address = a_address_q;
  assign bus_io.m_a_mask    = a_mask_q;
  assign bus_io.m_a_data    = a_data_q;
  assign bus_io.m_a_corrupt = a_corrupt_q;
  assign outstanding_o      = outstanding_q;
  assign spurious_d_o       = spurious_q;
endmodule

// File: tb/tb_dma_channel_arbiter.sv
// tb_dma_channel_arbiter: directed vectors with A/D scoreboards and decoupled monitors
module tb_dma_channel_arbiter;
  localparam int NoC = 2;
  localparam int TL_RS = 4;
  typedef struct {
    logic [3:0]  src;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  op;
  } a_t;
  typedef struct {
    bit          spur;
    int          ch;
    logic [31:0] data;
  } d_t;
  logic clk;
  logic rst;
  logic [NoC-1:0] outstanding;
  logic spurious;
  int checks = 0;
  int errors = 0;
  int spur_cnt = 0;
  bit auto_d = 0;
  a_t exp_a[$];
  d_t exp_d[$];
  dma_channel_arbiter_if #(.NoC(NoC), .TL_RS(TL_RS)) bus ();
  dma_channel_arbiter #(.NoC(NoC), .TL_RS(TL_RS)) dut (
    .dma_clock_i   (clk),
    .dma_reset_i   (rst),
    .bus_io        (bus),
    .outstanding_o (outstanding),
    .spurious_d_o  (spurious)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // A monitor: every master A handshake must match the next expected request
  always @(negedge clk) begin
    if (!rst && bus.m_a_valid && bus.m_a_ready) begin
      if (exp_a.size() == 0) begin
        chk("a_unexpected", 32'(bus.m_a_source), 32'hFFFF);
      end else begin
        a_t e;
        e = exp_a.pop_front();
        chk("a_source", 32'(bus.m_a_source), 32'(e.src));
        chk("a_address", bus.m_a_address, e.addr);
        chk("a_data", bus.m_a_data, e.data);
        chk("a_opcode", 32'(bus.m_a_opcode), 32'(e.op));
        chk("a_size", 32'(bus.m_a_size), 32'd2);
      end
    end
  end
  // D monitor: routed beats reach one channel, spurious beats reach none
  always @(negedge clk) begin
    if (!rst && bus.m_d_valid) begin
      if (exp_d.size() == 0) begin
        chk("d_unexpected", 32'(bus.m_d_source), 32'hFFFF);
      end else begin
        d_t e;
        e = exp_d.pop_front();
        chk("d_ready", 32'(bus.m_d_ready), 32'd1);
        if (e.spur) begin
          chk("d_spur_no_valid", 32'(bus.ch_d_valid), 32'd0);
        end else begin
          chk("d_route_valid", 32'(bus.ch_d_valid), 32'(1 << e.ch));
          chk("d_route_data", bus.ch_d_data[e.ch*32 +: 32], e.data);
        end
      end
    end
  end
  always @(negedge clk) if (spurious === 1'b1) spur_cnt++;
  task automatic push_a(logic [3:0] src, logic [31:0] addr, logic [31:0] data, logic [2:0] op);
    a_t e;
    e.src = src;
    e.addr = addr;
    e.data = data;
    e.op = op;
    exp_a.push_back(e);
  endtask
  task automatic set_a(int ch, logic [31:0] addr, logic [31:0] data, logic [2:0] op);
    bus.ch_a_opcode[ch*3 +: 3] = op;
    bus.ch_a_param[ch*3 +: 3] = 3'd0;
    bus.ch_a_size[ch*4 +: 4] = 4'd2;
    bus.ch_a_address[ch*32 +: 32] = addr;
    bus.ch_a_mask[ch*4 +: 4] = 4'hF;
    bus.ch_a_data[ch*32 +: 32] = data;
    bus.ch_a_corrupt[ch] = 1'b0;
    bus.ch_a_valid[ch] = 1'b1;
  endtask
  task automatic send_d(logic [3:0] src, bit spur, logic [31:0] data);
    d_t e;
    bus.m_d_valid = 1'b1;
    bus.m_d_source = src;
    bus.m_d_opcode = 3'd1;
    bus.m_d_data = data;
    e.spur = spur;
    e.ch = int'(src);
    e.data = data;
    exp_d.push_back(e);
  endtask
  // one clock; with auto_d set, answer every A handshake on the following cycle
  task automatic tick();
    int p;
    @(negedge clk);
    p = (bus.m_a_valid && bus.m_a_ready) ? int'(bus.m_a_source) : -1;
    @(posedge clk);
    #1;
    if (auto_d) begin
      bus.m_d_valid = 1'b0;
      if (p >= 0) send_d(4'(p), 1'b0, 32'hD000_0000 | 32'(p));
    end
  endtask
  task automatic d_beat(logic [3:0] src, bit spur, logic [31:0] data);
    send_d(src, spur, data);
    tick();
    bus.m_d_valid = 1'b0;
  endtask
  initial begin
    int acc;
    rst = 1;
    bus.ch_a_opcode = '0; bus.ch_a_param = '0; bus.ch_a_size = '0;
    bus.ch_a_address = '0; bus.ch_a_mask = '0; bus.ch_a_data = '0;
    bus.ch_a_corrupt = '0; bus.ch_a_valid = '0; bus.ch_d_ready = 2'b11;
    bus.m_a_ready = 1'b1;
    bus.m_d_opcode = '0; bus.m_d_param = '0; bus.m_d_size = 4'd2; bus.m_d_source = '0;
    bus.m_d_denied = 1'b0; bus.m_d_data = '0; bus.m_d_corrupt = 1'b0; bus.m_d_valid = 1'b0;
    #2;
    chk("rst_a_valid", 32'(bus.m_a_valid), 32'd0);
    chk("rst_outstanding", 32'(outstanding), 32'd0);
    chk("rst_spurious", 32'(spurious), 32'd0);
    chk("rst_a_address", bus.m_a_address, 32'd0);
    @(posedge clk); #1;
    rst = 0;
    // single request on channel 0
    set_a(0, 32'h1000, 32'h0, 3'd4);
    push_a(4'd0, 32'h1000, 32'h0, 3'd4);
    #1 chk("single_grant", 32'(bus.ch_a_ready), 32'b01);
    tick();
    bus.ch_a_valid = '0;
    chk("single_a_valid", 32'(bus.m_a_valid), 32'd1);
    chk("single_source", 32'(bus.m_a_source), 32'd0);
    chk("single_outstanding", 32'(outstanding), 32'b01);
    tick();
    chk("single_a_drained", 32'(bus.m_a_valid), 32'd0);
    d_beat(4'd0, 1'b0, 32'hDEADBEEF);
    chk("single_out_clear", 32'(outstanding), 32'd0);
    // fairness: rr points at channel 1 after the single request
    auto_d = 1;
    for (int i = 0; i < 6; i++) push_a(4'((i + 1) % 2), (i % 2) ? 32'h2000 : 32'h3000, 32'h0, 3'd4);
    set_a(0, 32'h2000, 32'h0, 3'd4);
    set_a(1, 32'h3000, 32'h0, 3'd4);
    acc = 0;
    for (int c = 0; c < 80 && acc < 6; c++) begin
      #1;
      if (|(bus.ch_a_valid & bus.ch_a_ready)) acc++;
      tick();
    end
    chk("fair_accepts", 32'(acc), 32'd6);
    bus.ch_a_valid = '0;
    repeat (8) tick();
    chk("fair_out_clear", 32'(outstanding), 32'd0);
    // backpressure: hold the A stage for five cycles
    bus.m_a_ready = 1'b0;
    set_a(0, 32'h4000, 32'h11111111, 3'd0);
    set_a(1, 32'h5000, 32'h22222222, 3'd0);
    push_a(4'd1, 32'h5000, 32'h22222222, 3'd0);
    push_a(4'd0, 32'h4000, 32'h11111111, 3'd0);
    #1 chk("bp_first_grant", 32'(bus.ch_a_ready), 32'b10);
    tick();
    bus.ch_a_valid[1] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_valid", 32'(bus.m_a_valid), 32'd1);
      chk("bp_hold_address", bus.m_a_address, 32'h5000);
      chk("bp_hold_data", bus.m_a_data, 32'h22222222);
      chk("bp_no_grant", 32'(bus.ch_a_ready), 32'd0);
      tick();
    end
    bus.m_a_ready = 1'b1;
    #1 chk("bp_release_grant", 32'(bus.ch_a_ready), 32'b01);
    tick();
    bus.ch_a_valid = '0;
    repeat (6) tick();
    chk("bp_out_clear", 32'(outstanding), 32'd0);
    // outstanding block: ch0 held off until its D beat completes
    auto_d = 0;
    set_a(0, 32'h6000, 32'h0, 3'd4);
    push_a(4'd0, 32'h6000, 32'h0, 3'd4);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("blk_ch0_held", 32'(bus.ch_a_ready), 32'd0);
      tick();
    end
    set_a(1, 32'h7000, 32'h0, 3'd4);
    push_a(4'd1, 32'h7000, 32'h0, 3'd4);
    #1 chk("blk_ch1_served", 32'(bus.ch_a_ready), 32'b10);
    tick();
    bus.ch_a_valid[1] = 1'b0;
    send_d(4'd0, 1'b0, 32'h0A0A0A0A);
    #1 chk("blk_no_same_cycle", 32'(bus.ch_a_ready), 32'd0);
    tick();
    bus.m_d_valid = 1'b0;
    #1 chk("blk_reissue_next", 32'(bus.ch_a_ready), 32'b01);
    push_a(4'd0, 32'h6000, 32'h0, 3'd4);
    tick();
    bus.ch_a_valid = '0;
    tick();
    d_beat(4'd1, 1'b0, 32'h1B1B1B1B);
    d_beat(4'd0, 1'b0, 32'h0C0C0C0C);
    chk("blk_out_clear", 32'(outstanding), 32'd0);
    // spurious D: idle channel, then nonzero upper source bits
    d_beat(4'd1, 1'b1, 32'h55555555);
    chk("spur_pulse", 32'(spurious), 32'd1);
    tick();
    chk("spur_pulse_end", 32'(spurious), 32'd0);
    set_a(0, 32'hA000, 32'h0, 3'd4);
    push_a(4'd0, 32'hA000, 32'h0, 3'd4);
    tick();
    bus.ch_a_valid = '0;
    tick();
    d_beat(4'd4, 1'b1, 32'h66666666);
    chk("spur_hi_pulse", 32'(spurious), 32'd1);
    chk("spur_hi_kept", 32'(outstanding), 32'b01);
    d_beat(4'd0, 1'b0, 32'h77777777);
    chk("spur_real_clear", 32'(outstanding), 32'd0);
    // asynchronous reset mid-flight
    set_a(0, 32'h8000, 32'h0, 3'd4);
    set_a(1, 32'h9000, 32'h0, 3'd4);
    push_a(4'd1, 32'h9000, 32'h0, 3'd4);
    tick();
    tick();
    bus.m_a_ready = 1'b0;
    bus.ch_a_valid = '0;
    chk("rmf_outstanding", 32'(outstanding), 32'b11);
    chk("rmf_a_valid", 32'(bus.m_a_valid), 32'd1);
    #2 rst = 1;
    #1;
    chk("rmf_rst_a_valid", 32'(bus.m_a_valid), 32'd0);
    chk("rmf_rst_outstanding", 32'(outstanding), 32'd0);
    chk("rmf_rst_address", bus.m_a_address, 32'd0);
    tick();
    rst = 0;
    bus.m_a_ready = 1'b1;
    d_beat(4'd0, 1'b1, 32'h88888888);
    chk("rmf_late_spur", 32'(spurious), 32'd1);
    repeat (3) tick();
    chk("end_a_queue", 32'(exp_a.size()), 32'd0);
    chk("end_d_queue", 32'(exp_d.size()), 32'd0);
    chk("end_spur_count", 32'(spur_cnt), 32'd3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dma_channel_arbiter.md
Name: dma_channel_arbiter

Overview:
- Shares one TileLink-UL master port between the NoC per-channel master ports of the multi-channel DMA controller.
- Round-robin arbitration across channel A requests, feeding a single registered A output stage.
- Each request is tagged with its channel index in a_source; D responses are routed back to the issuing channel by that source.
- One outstanding request per channel; single-beat transfers only (size <= 2).

Parameters:
- NoC, 2, number of DMA channels (>= 2).
- TL_RS, 4, TileLink source width on the master port; requires TL_RS >= $clog2(NoC).

Ports:
- dma_clock_i  input  1  clock.
- dma_reset_i  input  1  asynchronous active-high reset.
- ch_a_opcode  input  3*NoC  per-channel A opcode.
- ch_a_param  input  3*NoC  per-channel A param.
- ch_a_size  input  4*NoC  per-channel A size.
- ch_a_address  input  32*NoC  per-channel A address.
- ch_a_mask  input  4*NoC  per-channel A byte mask.
- ch_a_data  input  32*NoC  per-channel A data.
- ch_a_corrupt  input  NoC  per-channel A corrupt.
- ch_a_valid  input  NoC  per-channel A valid.
- ch_a_ready  output  NoC  per-channel A ready (grant).
- ch_d_opcode  output  3*NoC  routed D opcode.
- ch_d_param  output  2*NoC  routed D param.
- ch_d_size  output  4*NoC  routed D size.
- ch_d_denied  output  NoC  routed D denied.
- ch_d_data  output  32*NoC  routed D data.
- ch_d_corrupt  output  NoC  routed D corrupt.
- ch_d_valid  output  NoC  routed D valid.
- ch_d_ready  input  NoC  per-channel D ready.
- m_a_opcode / m_a_param / m_a_size  output  3/3/4  master A fields.
- m_a_source  output  TL_RS  channel index, zero-extended.
- m_a_address / m_a_mask / m_a_data / m_a_corrupt  output  32/4/32/1  master A fields.
- m_a_valid  output  1  master A valid.
- m_a_ready  input  1  master A ready.
- m_d_opcode / m_d_param / m_d_size / m_d_source  input  3/2/4/TL_RS  master D fields.
- m_d_denied / m_d_data / m_d_corrupt  input  1/32/1  master D fields.
- m_d_valid  input  1  master D valid.
- m_d_ready  output  1  master D ready.
- outstanding_o  output  NoC  per-channel request-in-flight flags.
- spurious_d_o  output  1  one-cycle pulse when a D beat is dropped.

Behaviour:
- Reset (async) clears m_a_valid, all outstanding flags and spurious_d_o; rr_ptr resets to 0. All m_a_* data fields reset to 0.
- Eligibility: eligible[i] = ch_a_valid[i] & ~outstanding[i], using the registered outstanding value.
- slot_free = ~m_a_valid | m_a_ready.
- Grant (combinational): first eligible channel scanning rr_ptr, rr_ptr+1, ..., wrapping mod NoC.
- ch_a_ready[g] = slot_free for the granted channel only; ch_a_ready = 0 for all other channels.
- Accept occurs when slot_free and any channel is eligible. On accept:
  - A stage loads the winner's fields; m_a_source = g; m_a_valid <= 1.
  - outstanding[g] <= 1.
  - rr_ptr <= (g+1) mod NoC.
- slot_free with no eligible channel: m_a_valid <= 0.
- Latency: channel handshake to m_a_valid is 1 cycle. Back-to-back accepts are allowed every cycle while m_a_ready = 1.
- m_a_* fields are held stable while m_a_valid & ~m_a_ready.
- D routing: idx = m_d_source[$clog2(NoC)-1:0].
  - Valid beat when the upper source bits are 0, idx < NoC and outstanding[idx] = 1.
  - Valid beat: ch_d_valid[idx] = m_d_valid; all D fields are broadcast to every channel; m_d_ready = ch_d_ready[idx].
  - Any other beat: m_d_ready = 1, no ch_d_valid is raised, and spurious_d_o = 1 next cycle.
- outstanding[idx] clears on the D handshake.
- Same-cycle D clear for channel i and a new grant to channel i cannot occur, because eligibility uses the registered flag. The earliest reissue is the cycle after the clear.
- Requests with size > 2 are forwarded unchanged; the single-beat restriction is the requester's responsibility.

Test Plan:
- Single request: ch0 A with address 0x1000, Get, size 2 -> m_a_valid at cycle+1 with source 0. D beat with source 0 and data 0xDEADBEEF -> ch_d_valid[0] and data delivered; outstanding_o[0] returns to 0.
- Fairness: ch0 and ch1 held valid continuously with instant D responses -> grants alternate 0,1,0,1. Neither channel waits more than NoC grants.
- Backpressure: m_a_ready = 0 for 5 cycles -> m_a_* stable, ch_a_ready = 0, no field changes; release -> one handshake.
- Outstanding block: ch0 issues, D withheld, ch0 valid again -> ch0 not granted and ch1 is served. The D handshake enables ch0 the next cycle.
- Spurious D: D with source 1 while outstanding_o = 0 -> m_d_ready = 1, no ch_d_valid, spurious_d_o pulses once.
- Reset mid-flight: assert dma_reset_i with m_a_valid = 1 and outstanding = 2'b11 -> outputs clear immediately (async). A later D beat is treated as spurious.
